// File: rtl/calc2_alu_sched.sv
// rtl/calc2_alu_sched.sv - four-port two-cycle request capture, per-port FIFOs, arbitrated shared pipelined ALU
// Build option: CALC2_SCHED_FIXED_PRIO_EN selects fixed priority (port 1 first) in place of round-robin.
module calc2_alu_sched #(
    parameter int ALU_LAT = 2,
    parameter int QDEPTH  = 4
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [3:0]  req1_cmd_in,
    input  logic [31:0] req1_data_in,
    input  logic [1:0]  req1_tag_in,
    input  logic [3:0]  req2_cmd_in,
    input  logic [31:0] req2_data_in,
    input  logic [1:0]  req2_tag_in,
    input  logic [3:0]  req3_cmd_in,
    input  logic [31:0] req3_data_in,
    input  logic [1:0]  req3_tag_in,
    input  logic [3:0]  req4_cmd_in,
    input  logic [31:0] req4_data_in,
    input  logic [1:0]  req4_tag_in,
    output logic [1:0]  out_resp1,
    output logic [31:0] out_data1,
    output logic [1:0]  out_tag1,
    output logic [1:0]  out_resp2,
    output logic [31:0] out_data2,
    output logic [1:0]  out_tag2,
    output logic [1:0]  out_resp3,
    output logic [31:0] out_data3,
    output logic [1:0]  out_tag3,
    output logic [1:0]  out_resp4,
    output logic [31:0] out_data4,
    output logic [1:0]  out_tag4,
    output logic [3:0]  ovf_err
);
    localparam int NP = 4;
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int LS = ALU_LAT - 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(QDEPTH - 1);
    localparam logic [3:0]    CNT_FULL = 4'(QDEPTH);

    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;
    localparam logic [1:0] RESP_OK  = 2'b01;
    localparam logic [1:0] RESP_ERR = 2'b10;

    typedef enum logic {CAP_IDLE, CAP_OP2} cap_state_t;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  tag;
    } req_t;

    logic [3:0]  cmd_in  [NP];
    logic [31:0] data_in [NP];
    logic [1:0]  tag_in  [NP];

    assign cmd_in[0]  = req1_cmd_in;
    assign cmd_in[1]  = req2_cmd_in;
    assign cmd_in[2]  = req3_cmd_in;
    assign cmd_in[3]  = req4_cmd_in;
    assign data_in[0] = req1_data_in;
    assign data_in[1] = req2_data_in;
    assign data_in[2] = req3_data_in;
    assign data_in[3] = req4_data_in;
    assign tag_in[0]  = req1_tag_in;
    assign tag_in[1]  = req2_tag_in;
    assign tag_in[2]  = req3_tag_in;
    assign tag_in[3]  = req4_tag_in;

    cap_state_t  cap_state_q [NP];
    logic [3:0]  cap_cmd_q   [NP];
    logic [31:0] cap_op1_q   [NP];
    logic [1:0]  cap_tag_q   [NP];

    // The cmd input is deliberately not looked at while waiting for operand 2.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NP; p++) begin
                cap_state_q[p] <= CAP_IDLE;
                cap_cmd_q[p]   <= 4'd0;
                cap_op1_q[p]   <= 32'd0;
                cap_tag_q[p]   <= 2'd0;
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                case (cap_state_q[p])
                    CAP_IDLE: begin
                        if (cmd_in[p] != 4'd0) begin
                            cap_state_q[p] <= CAP_OP2;
                            cap_cmd_q[p]   <= cmd_in[p];
                            cap_op1_q[p]   <= data_in[p];
                            cap_tag_q[p]   <= tag_in[p];
                        end
                    end
                    default: cap_state_q[p] <= CAP_IDLE;
                endcase
            end
        end
    end

    req_t          fifo_mem [NP][2**PW];
    logic [PW-1:0] wr_ptr_q [NP];
    logic [PW-1:0] wr_ptr_d [NP];
    logic [PW-1:0] rd_ptr_q [NP];
    logic [PW-1:0] rd_ptr_d [NP];
    logic [3:0]    count_q  [NP];
    logic [3:0]    count_d  [NP];
    logic [NP-1:0] ovf_q;
    logic [NP-1:0] ovf_d;
    logic [NP-1:0] enq_req;
    logic [NP-1:0] enq_ok;
    logic [NP-1:0] pop;
    logic [NP-1:0] nonempty;
    req_t          enq_entry [NP];

    logic          grant_vld;
    logic [1:0]    grant_idx;

    // Fullness is judged before this cycle's pop, so a pop does not rescue a colliding enqueue.
    always_comb begin
        enq_req  = '0;
        enq_ok   = '0;
        pop      = '0;
        nonempty = '0;
        for (int p = 0; p < NP; p++) begin
            enq_req[p]   = (cap_state_q[p] == CAP_OP2);
            enq_ok[p]    = enq_req[p] && (count_q[p] != CNT_FULL);
            pop[p]       = grant_vld && (grant_idx == 2'(p));
            nonempty[p]  = (count_q[p] != 4'd0);
            enq_entry[p] = {cap_cmd_q[p], cap_op1_q[p], data_in[p], cap_tag_q[p]};
        end
        ovf_d = ovf_q | (enq_req & ~enq_ok);
    end

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            wr_ptr_d[p] = wr_ptr_q[p];
            rd_ptr_d[p] = rd_ptr_q[p];
            count_d[p]  = count_q[p];
            if (enq_ok[p]) begin
                wr_ptr_d[p] = (wr_ptr_q[p] == PTR_LAST) ? '0 : wr_ptr_q[p] + 1'b1;
            end
            if (pop[p]) begin
                rd_ptr_d[p] = (rd_ptr_q[p] == PTR_LAST) ? '0 : rd_ptr_q[p] + 1'b1;
            end
            case ({enq_ok[p], pop[p]})
                2'b10:   count_d[p] = count_q[p] + 4'd1;
                2'b01:   count_d[p] = count_q[p] - 4'd1;
                default: count_d[p] = count_q[p];
            endcase
        end
    end

    always_ff @(posedge c_clk) begin
        for (int p = 0; p < NP; p++) begin
            if (enq_ok[p]) begin
                fifo_mem[p][wr_ptr_q[p]] <= enq_entry[p];
            end
        end
    end

`ifdef CALC2_SCHED_FIXED_PRIO_EN
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 2'd0;
        for (int i = NP - 1; i >= 0; i--) begin
            if (nonempty[i]) begin
                grant_vld = 1'b1;
                grant_idx = 2'(i);
            end
        end
    end
`else
    logic [1:0] rr_q;
    logic [1:0] rr_d;
    logic [1:0] rr_cand;

    // Scan from the farthest offset down so the port nearest the pointer wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 2'd0;
        rr_cand   = 2'd0;
        for (int i = NP - 1; i >= 0; i--) begin
            rr_cand = rr_q + 2'(i);
            if (nonempty[rr_cand]) begin
                grant_vld = 1'b1;
                grant_idx = rr_cand;
            end
        end
        rr_d = grant_vld ? grant_idx + 2'd1 : rr_q;
    end
`endif

    req_t        head;
    logic [32:0] alu_sum;
    logic [1:0]  alu_resp;
    logic [31:0] alu_data;

    assign head = fifo_mem[grant_idx][rd_ptr_q[grant_idx]];

    always_comb begin
        alu_resp = RESP_ERR;
        alu_data = 32'd0;
        alu_sum  = {1'b0, head.op1} + {1'b0, head.op2};
        case (head.cmd)
            CMD_ADD: begin
                if (!alu_sum[32]) begin
                    alu_resp = RESP_OK;
                    alu_data = alu_sum[31:0];
                end
            end
            CMD_SUB: begin
                if (head.op2 <= head.op1) begin
                    alu_resp = RESP_OK;
                    alu_data = head.op1 - head.op2;
                end
            end
            CMD_SHL: begin
                alu_resp = RESP_OK;
                alu_data = head.op1 << head.op2[4:0];
            end
            CMD_SHR: begin
                alu_resp = RESP_OK;
                alu_data = head.op1 >> head.op2[4:0];
            end
            default: begin
                alu_resp = RESP_ERR;
                alu_data = 32'd0;
            end
        endcase
    end

    logic [ALU_LAT-1:0] pv_q;
    logic [ALU_LAT-1:0] pv_d;
    logic [1:0]         pport_q [ALU_LAT];
    logic [1:0]         pport_d [ALU_LAT];
    logic [1:0]         ptag_q  [ALU_LAT];
    logic [1:0]         ptag_d  [ALU_LAT];
    logic [1:0]         presp_q [ALU_LAT];
    logic [1:0]         presp_d [ALU_LAT];
    logic [31:0]        pdata_q [ALU_LAT];
    logic [31:0]        pdata_d [ALU_LAT];

    // Stage 0 holds the finished result; the remaining stages only add latency.
    always_comb begin
        pv_d       = '0;
        pv_d[0]    = grant_vld;
        pport_d[0] = grant_vld ? grant_idx : 2'd0;
        ptag_d[0]  = grant_vld ? head.tag  : 2'd0;
        presp_d[0] = grant_vld ? alu_resp  : 2'b00;
        pdata_d[0] = grant_vld ? alu_data  : 32'd0;
        for (int k = 1; k < ALU_LAT; k++) begin
            pv_d[k]    = pv_q[k-1];
            pport_d[k] = pport_q[k-1];
            ptag_d[k]  = ptag_q[k-1];
            presp_d[k] = presp_q[k-1];
            pdata_d[k] = pdata_q[k-1];
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NP; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                count_q[p]  <= 4'd0;
            end
            ovf_q <= '0;
            pv_q  <= '0;
            for (int k = 0; k < ALU_LAT; k++) begin
                pport_q[k] <= 2'd0;
                ptag_q[k]  <= 2'd0;
                presp_q[k] <= 2'b00;
                pdata_q[k] <= 32'd0;
            end
`ifndef CALC2_SCHED_FIXED_PRIO_EN
            rr_q <= 2'd0;
`endif
        end else begin
            for (int p = 0; p < NP; p++) begin
                wr_ptr_q[p] <= wr_ptr_d[p];
                rd_ptr_q[p] <= rd_ptr_d[p];
                count_q[p]  <= count_d[p];
            end
            ovf_q <= ovf_d;
            pv_q  <= pv_d;
            for (int k = 0; k < ALU_LAT; k++) begin
                pport_q[k] <= pport_d[k];
                ptag_q[k]  <= ptag_d[k];
                presp_q[k] <= presp_d[k];
                pdata_q[k] <= pdata_d[k];
            end
`ifndef CALC2_SCHED_FIXED_PRIO_EN
            rr_q <= rr_d;
`endif
        end
    end

    logic [1:0]  resp_o [NP];
    logic [31:0] data_o [NP];
    logic [1:0]  tag_o  [NP];

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            resp_o[p] = 2'b00;
            data_o[p] = 32'd0;
            tag_o[p]  = 2'd0;
        end
        if (pv_q[LS]) begin
            resp_o[pport_q[LS]] = presp_q[LS];
            data_o[pport_q[LS]] = pdata_q[LS];
            tag_o[pport_q[LS]]  = ptag_q[LS];
        end
    end

    assign out_resp1 = resp_o[0];
    assign out_data1 = data_o[0];
    assign out_tag1  = tag_o[0];
    assign out_resp2 = resp_o[1];
    assign out_data2 = data_o[1];
    assign out_tag2  = tag_o[1];
    assign out_resp3 = resp_o[2];
    assign out_data3 = data_o[2];
    assign out_tag3  = tag_o[2];
    assign out_resp4 = resp_o[3];
    assign out_data4 = data_o[3];
    assign out_tag4  = tag_o[3];
    assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_calc2_alu_sched.sv
// tb/tb_calc2_alu_sched.sv - scoreboard bench for calc2_alu_sched
module tb_calc2_alu_sched;
    localparam int ALU_LAT = 2;
    localparam int QDEPTH  = 4;

    typedef struct packed {
        logic [1:0]  tag;
        logic [1:0]  resp;
        logic [31:0] data;
        logic [31:0] at;
    } rsp_t;

    logic        c_clk = 1'b0;
    logic        reset;
    logic [3:0]  cmd  [4];
    logic [31:0] din  [4];
    logic [1:0]  tin  [4];
    logic [1:0]  o_resp [4];
    logic [31:0] o_data [4];
    logic [1:0]  o_tag  [4];
    logic [3:0]  ovf_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   bus_bad  = 0;
    rsp_t obs_q [4][$];
    rsp_t exp_q [4][$];

    always #5 c_clk = ~c_clk;
    always @(posedge c_clk) cyc <= cyc + 1;

    calc2_alu_sched #(.ALU_LAT(ALU_LAT), .QDEPTH(QDEPTH)) dut (
        .c_clk(c_clk), .reset(reset),
        .req1_cmd_in(cmd[0]), .req1_data_in(din[0]), .req1_tag_in(tin[0]),
        .req2_cmd_in(cmd[1]), .req2_data_in(din[1]), .req2_tag_in(tin[1]),
        .req3_cmd_in(cmd[2]), .req3_data_in(din[2]), .req3_tag_in(tin[2]),
        .req4_cmd_in(cmd[3]), .req4_data_in(din[3]), .req4_tag_in(tin[3]),
        .out_resp1(o_resp[0]), .out_data1(o_data[0]), .out_tag1(o_tag[0]),
        .out_resp2(o_resp[1]), .out_data2(o_data[1]), .out_tag2(o_tag[1]),
        .out_resp3(o_resp[2]), .out_data3(o_data[2]), .out_tag3(o_tag[2]),
        .out_resp4(o_resp[3]), .out_data4(o_data[3]), .out_tag4(o_tag[3]),
        .ovf_err(ovf_err)
    );

    // Responses are collected mid-cycle; idle buses must be all-zero and at most one port active.
    always @(negedge c_clk) begin
        for (int p = 0; p < 4; p++) begin
            if (o_resp[p] != 2'b00)
                obs_q[p].push_back({o_tag[p], o_resp[p], o_data[p], 32'(cyc)});
            else if (o_data[p] != 32'd0 || o_tag[p] != 2'd0)
                bus_bad <= bus_bad + 1;
        end
        if ($countones({o_resp[0] != 2'b00, o_resp[1] != 2'b00, o_resp[2] != 2'b00, o_resp[3] != 2'b00}) > 1)
            bus_bad <= bus_bad + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic rsp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                   input logic [1:0] t, input int at);
        rsp_t        r;
        logic [63:0] wide;
        r.tag  = t;
        r.resp = 2'b10;
        r.data = 32'd0;
        r.at   = 32'(at);
        wide   = 64'(a) + 64'(b);
        case (c)
            4'd1: if (wide <= 64'h0000_0000_FFFF_FFFF) begin r.resp = 2'b01; r.data = wide[31:0]; end
            4'd2: if (a >= b) begin r.resp = 2'b01; r.data = a - b; end
            4'd5: begin r.resp = 2'b01; r.data = a << (b & 32'd31); end
            4'd6: begin r.resp = 2'b01; r.data = a >> (b & 32'd31); end
            default: ;
        endcase
        return r;
    endfunction

    task automatic tick;
        @(posedge c_clk);
        #1;
    endtask

    task automatic idle_all;
        for (int p = 0; p < 4; p++) begin
            cmd[p] = 4'd0;
            din[p] = 32'd0;
            tin[p] = 2'd0;
        end
    endtask

    task automatic set_cmd(input int p, input logic [3:0] c, input logic [31:0] a, input logic [1:0] t);
        cmd[p] = c;
        din[p] = a;
        tin[p] = t;
    endtask

    // A junk nonzero cmd rides along with operand 2; the capture logic must ignore it.
    task automatic set_op2(input int p, input logic [31:0] b);
        cmd[p] = 4'd3;
        din[p] = b;
        tin[p] = 2'd1;
    endtask

    task automatic clear_queues;
        for (int p = 0; p < 4; p++) begin
            obs_q[p].delete();
            exp_q[p].delete();
        end
        bus_bad = 0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        idle_all();
        tick();
        tick();
        for (int p = 0; p < 4; p++) begin
            n_checks++;
            if (o_resp[p] !== 2'b00 || o_data[p] !== 32'd0 || o_tag[p] !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_out port%0d got resp=%b data=%h tag=%0d want 0", p + 1, o_resp[p], o_data[p], o_tag[p]);
            end
        end
        n_checks++;
        if (ovf_err !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ovf got %b want 0000", ovf_err);
        end
        reset = 1'b1;
        clear_queues();
    endtask

    task automatic test_alu;
        int   t0;
        rsp_t o, e;
        clear_queues();
        t0 = cyc;
        set_cmd(0, 4'd1, 32'h22, 2'd2);
        exp_q[0].push_back(model(4'd1, 32'h22, 32'h3, 2'd2, t0 + 2 + ALU_LAT));
        tick();
        set_op2(0, 32'h3);
        tick();
        idle_all();
        repeat (8) tick();
        t0 = cyc;
        set_cmd(1, 4'd2, 32'h3, 2'd1);
        set_cmd(2, 4'd1, 32'hFFFF_FFFF, 2'd3);
        set_cmd(3, 4'd4, 32'h10, 2'd0);
        exp_q[1].push_back(model(4'd2, 32'h3, 32'h22, 2'd1, 0));
        exp_q[2].push_back(model(4'd1, 32'hFFFF_FFFF, 32'h1, 2'd3, 0));
        exp_q[3].push_back(model(4'd4, 32'h10, 32'h5, 2'd0, 0));
        tick();
        set_op2(1, 32'h22);
        set_op2(2, 32'h1);
        set_op2(3, 32'h5);
        tick();
        idle_all();
        repeat (8) tick();
        t0 = cyc;
        set_cmd(0, 4'd5, 32'h1, 2'd0);
        exp_q[0].push_back(model(4'd5, 32'h1, 32'd31, 2'd0, t0 + 2 + ALU_LAT));
        tick();
        set_op2(0, 32'd31);
        tick();
        set_cmd(0, 4'd6, 32'h8000_0000, 2'd3);
        exp_q[0].push_back(model(4'd6, 32'h8000_0000, 32'h21, 2'd3, t0 + 4 + ALU_LAT));
        tick();
        set_op2(0, 32'h21);
        tick();
        idle_all();
        repeat (10) tick();
        n_checks++;
        if (exp_q[0].size() == 3 && (exp_q[0][0].data !== 32'h25 || exp_q[0][1].data !== 32'h8000_0000 || exp_q[0][2].data !== 32'h4000_0000)) begin
            n_fail++;
            $display("FAIL alu_model got %h %h %h want 25 80000000 40000000", exp_q[0][0].data, exp_q[0][1].data, exp_q[0][2].data);
        end
        for (int p = 0; p < 4; p++) begin
            n_checks++;
            if (obs_q[p].size() !== exp_q[p].size()) begin
                n_fail++;
                $display("FAIL alu_count port%0d got %0d want %0d", p + 1, obs_q[p].size(), exp_q[p].size());
            end
            while (obs_q[p].size() > 0 && exp_q[p].size() > 0) begin
                o = obs_q[p].pop_front();
                e = exp_q[p].pop_front();
                n_checks++;
                if (o.tag !== e.tag || o.resp !== e.resp || o.data !== e.data || (e.at != 0 && o.at !== e.at)) begin
                    n_fail++;
                    $display("FAIL alu_rsp port%0d got tag=%0d resp=%b data=%h cyc=%0d want tag=%0d resp=%b data=%h cyc=%0d",
                             p + 1, o.tag, o.resp, o.data, o.at, e.tag, e.resp, e.data, e.at);
                end
            end
        end
        n_checks++;
        if (bus_bad !== 0) begin
            n_fail++;
            $display("FAIL alu_idle_bus got %0d violations want 0", bus_bad);
        end
        clear_queues();
    endtask

    task automatic test_arbitration;
        int   t1;
        rsp_t o, e;
        clear_queues();
        set_cmd(2, 4'd1, 32'h100, 2'd0);
        exp_q[2].push_back(model(4'd1, 32'h100, 32'h1, 2'd0, cyc + 2 + ALU_LAT));
        tick();
        set_op2(2, 32'h1);
        tick();
        t1 = cyc;
        for (int p = 0; p < 4; p++) begin
            set_cmd(p, 4'd1, 32'(p * 16), 2'(p));
`ifdef CALC2_SCHED_FIXED_PRIO_EN
            exp_q[p].push_back(model(4'd1, 32'(p * 16), 32'd7, 2'(p), t1 + 2 + ALU_LAT + p));
`else
            exp_q[p].push_back(model(4'd1, 32'(p * 16), 32'd7, 2'(p), t1 + 2 + ALU_LAT + ((p + 1) % 4)));
`endif
        end
        tick();
        for (int p = 0; p < 4; p++) set_op2(p, 32'd7);
        tick();
        idle_all();
        repeat (10) tick();
        for (int p = 0; p < 4; p++) begin
            n_checks++;
            if (obs_q[p].size() !== exp_q[p].size()) begin
                n_fail++;
                $display("FAIL arb_count port%0d got %0d want %0d", p + 1, obs_q[p].size(), exp_q[p].size());
            end
            while (obs_q[p].size() > 0 && exp_q[p].size() > 0) begin
                o = obs_q[p].pop_front();
                e = exp_q[p].pop_front();
                n_checks++;
                if (o.tag !== e.tag || o.resp !== e.resp || o.data !== e.data || o.at !== e.at) begin
                    n_fail++;
                    $display("FAIL arb_rsp port%0d got tag=%0d data=%h cyc=%0d want tag=%0d data=%h cyc=%0d",
                             p + 1, o.tag, o.data, o.at, e.tag, e.data, e.at);
                end
            end
        end
        clear_queues();
    endtask

    task automatic test_overflow;
        int         cnt [4];
        int         rr;
        int         g;
        int         idx;
        int         nreq;
        logic [3:0] ovf_m;
        logic [3:0] enq;
        rsp_t       o, e;
        nreq  = 4 * QDEPTH + 4;
        rr    = 0;
        ovf_m = 4'b0000;
        for (int p = 0; p < 4; p++) cnt[p] = 0;
        idle_all();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        clear_queues();
        for (int c = 0; c < 2 * nreq; c++) begin
            for (int p = 0; p < 4; p++) begin
                if (c % 2 == 0) set_cmd(p, 4'd1, 32'((p + 1) << 16) + 32'(c / 2), 2'(c / 2));
                else            set_op2(p, 32'(c / 2 + 1));
            end
            g = -1;
            for (int i = 0; i < 4; i++) begin
`ifdef CALC2_SCHED_FIXED_PRIO_EN
                idx = i;
`else
                idx = (rr + i) % 4;
`endif
                if (g < 0 && cnt[idx] > 0) g = idx;
            end
            enq = 4'b0000;
            if (c % 2 == 1) begin
                for (int p = 0; p < 4; p++) begin
                    if (cnt[p] == QDEPTH) ovf_m[p] = 1'b1;
                    else begin
                        enq[p] = 1'b1;
                        exp_q[p].push_back(model(4'd1, 32'((p + 1) << 16) + 32'(c / 2), 32'(c / 2 + 1), 2'(c / 2), 0));
                    end
                end
            end
            if (g >= 0) begin
                cnt[g] = cnt[g] - 1;
                rr = (g + 1) % 4;
            end
            for (int p = 0; p < 4; p++) if (enq[p]) cnt[p] = cnt[p] + 1;
            tick();
            n_checks++;
            if (ovf_err !== ovf_m) begin
                n_fail++;
                $display("FAIL ovf_err step=%0d got %b want %b", c, ovf_err, ovf_m);
            end
        end
        idle_all();
        repeat (4 * QDEPTH + ALU_LAT + 20) tick();
        n_checks++;
        if (ovf_err[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_port1 got %b want 1", ovf_err[0]);
        end
        for (int p = 0; p < 4; p++) begin
            n_checks++;
            if (obs_q[p].size() !== exp_q[p].size()) begin
                n_fail++;
                $display("FAIL ovf_count port%0d got %0d want %0d", p + 1, obs_q[p].size(), exp_q[p].size());
            end
            while (obs_q[p].size() > 0 && exp_q[p].size() > 0) begin
                o = obs_q[p].pop_front();
                e = exp_q[p].pop_front();
                n_checks++;
                if (o.tag !== e.tag || o.resp !== e.resp || o.data !== e.data) begin
                    n_fail++;
                    $display("FAIL ovf_rsp port%0d got tag=%0d resp=%b data=%h want tag=%0d resp=%b data=%h",
                             p + 1, o.tag, o.resp, o.data, e.tag, e.resp, e.data);
                end
            end
        end
        n_checks++;
        if (bus_bad !== 0) begin
            n_fail++;
            $display("FAIL ovf_idle_bus got %0d violations want 0", bus_bad);
        end
        clear_queues();
    endtask

    task automatic test_reset_mid;
        int   t0;
        int   n_active;
        rsp_t o, e;
        clear_queues();
        for (int p = 0; p < 3; p++) set_cmd(p, 4'd1, 32'(p + 1), 2'(p));
        tick();
        for (int p = 0; p < 3; p++) set_op2(p, 32'h10);
        tick();
        idle_all();
        tick();
        tick();
        n_active = 0;
        for (int p = 0; p < 4; p++) if (o_resp[p] != 2'b00) n_active++;
        n_checks++;
        if (n_active !== 1) begin
            n_fail++;
            $display("FAIL rstmid_pre_active got %0d ports want 1", n_active);
        end
        #1;
        reset = 1'b0;
        #1;
        for (int p = 0; p < 4; p++) begin
            n_checks++;
            if (o_resp[p] !== 2'b00 || o_data[p] !== 32'd0 || o_tag[p] !== 2'd0) begin
                n_fail++;
                $display("FAIL rstmid_out port%0d got resp=%b data=%h tag=%0d want 0", p + 1, o_resp[p], o_data[p], o_tag[p]);
            end
        end
        n_checks++;
        if (ovf_err !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstmid_ovf got %b want 0000", ovf_err);
        end
        tick();
        reset = 1'b1;
        repeat (10) tick();
        for (int p = 0; p < 4; p++) begin
            n_checks++;
            if (obs_q[p].size() !== 0) begin
                n_fail++;
                $display("FAIL rstmid_quiet port%0d got %0d responses want 0", p + 1, obs_q[p].size());
            end
        end
        clear_queues();
        t0 = cyc;
        set_cmd(0, 4'd1, 32'h1234, 2'd1);
        exp_q[0].push_back(model(4'd1, 32'h1234, 32'h11, 2'd1, t0 + 2 + ALU_LAT));
        tick();
        set_op2(0, 32'h11);
        tick();
        idle_all();
        repeat (8) tick();
        n_checks++;
        if (obs_q[0].size() !== exp_q[0].size()) begin
            n_fail++;
            $display("FAIL rstmid_count got %0d want %0d", obs_q[0].size(), exp_q[0].size());
        end
        while (obs_q[0].size() > 0 && exp_q[0].size() > 0) begin
            o = obs_q[0].pop_front();
            e = exp_q[0].pop_front();
            n_checks++;
            if (o.tag !== e.tag || o.resp !== e.resp || o.data !== e.data || o.at !== e.at) begin
                n_fail++;
                $display("FAIL rstmid_rsp got tag=%0d resp=%b data=%h cyc=%0d want tag=%0d resp=%b data=%h cyc=%0d",
                         o.tag, o.resp, o.data, o.at, e.tag, e.resp, e.data, e.at);
            end
        end
        clear_queues();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_arbitration();
        test_overflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/calc2_alu_sched.md
# calc2_alu_sched

Shared-ALU scheduler for the calc2 four-port calculator. It captures two-cycle requests (command + operand 1, then operand 2) from four independent requester ports and queues them per port. A round-robin arbiter issues one queued request per cycle into a single pipelined ALU. Each result is returned on the originating port's response bus with its tag. It sits between the four calc2 request/response port groups and the one shared arithmetic/shift datapath.

## Interface
- `ALU_LAT`, default 2: ALU pipeline depth in cycles, legal range 1–4.
- `QDEPTH`, default 4: per-port request FIFO depth, legal range 2–8.
- `c_clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset; port name is `reset`, low = reset.
- `reqN_cmd_in` (N=1..4)  in  4  command, sampled in the command cycle: 1 add, 2 sub, 5 shl, 6 shr, 0 idle.
- `reqN_data_in` (N=1..4)  in  32  operand 1 in the command cycle, operand 2 in the following cycle.
- `reqN_tag_in` (N=1..4)  in  2  request tag, sampled in the command cycle.
- `out_respN` (N=1..4)  out  2  response code: 00 none, 01 success, 10 error.
- `out_dataN` (N=1..4)  out  32  result; 0 when the response code is not 01.
- `out_tagN` (N=1..4)  out  2  tag of the returned request.
- `ovf_err`  out  4  sticky per-port flag, bit N-1: a request was dropped because port N's FIFO was full.

## Operation
- **Per-port capture FSM**: IDLE→OP2 on a nonzero cmd (latch cmd, op1, tag). OP2→IDLE next cycle (latch op2, enqueue). The cmd input is ignored while in OP2. The next command may arrive in the cycle after OP2.
- **Full FIFO**: a request whose enqueue finds the FIFO full is dropped and sets `ovf_err[N-1]`. The flag clears only on reset.
- **Arbitration**: each cycle, among ports with non-empty FIFOs, grant the first port at or after the RR pointer. Pop that port's FIFO and issue to the ALU. The pointer then moves to grant+1, wrapping 4→1. Pointer reset value: port 1. Issue rate is at most 1 per cycle.
- **ALU function**:
  - add: 33-bit sum; a carry-out gives resp 10, data 0.
  - sub: op2 > op1 gives resp 10, data 0; otherwise op1−op2.
  - shl/shr: shift amount is op2[4:0], resp 01.
  - Any other nonzero cmd: resp 10, data 0.
- **Pipeline**: the ALU pipe carries port ID, tag, resp and data. At pipe exit, drive the originating port's out bus for exactly one cycle. All other ports show resp 00, data 0, tag 0. At most one port is driven per cycle, so there are no output collisions.
- **Ordering**: responses on a given port return in request order. Tag uniqueness is the requester's responsibility and is not checked.

## Timing
- Command cycle T, operand-2 cycle T+1. The entry is visible in the FIFO at T+2 and issues at T+2 at the earliest.
- The response is valid in cycle T+2+ALU_LAT when uncontended (T+4 at default). Each cycle of arbitration loss adds one cycle.
- Simultaneous enqueue and pop on the same FIFO in one cycle: both take effect, and the count is unchanged.
- All outputs reset to 0: out_resp/out_data/out_tag on all ports, and ovf_err.
- **Reset mid-operation**: outputs go to 0 immediately (asynchronous). FIFOs, capture FSMs, the ALU pipe and the RR pointer are cleared. In-flight requests produce no response after release.
- After reset deasserts, the first cmd may be sampled on the first rising edge.

## Configuration
- `CALC2_SCHED_FIXED_PRIO_EN`:
  - Defined: fixed priority, port 1 > 2 > 3 > 4. The RR pointer is removed.
  - Undefined: round-robin as described in Operation.
  - All other behaviour is identical in both builds.

## Test plan
1. Port 1: cmd 1, data 0x22, then 0x3, tag 2 → at T+4, out_resp1=01, out_data1=0x25, out_tag1=2. Other ports show 00.
2. Port 2: cmd 2, 0x3 then 0x22 → resp 10, data 0. Port 3: cmd 1, 0xFFFFFFFF + 0x1 → resp 10, data 0. Port 4: cmd 4 → resp 10.
3. Port 1: shl 0x1 by 31 → 0x80000000. Port 1: shr 0x80000000 by 0x21 → 0x40000000 (only op2[4:0]=1 used).
4. Port 3 sends a single add. Then all four ports send adds in the same cycle:
   - RR build: responses on ports 4, 1, 2, 3 in consecutive cycles.
   - `CALC2_SCHED_FIXED_PRIO_EN` build: ports 1, 2, 3, 4.
5. Ports 2–4 issue back-to-back continuously while port 1 sends QDEPTH+1 requests back-to-back → `ovf_err[0]`=1 exactly when the enqueue finds the FIFO full. Exactly the non-dropped requests return, in order.
6. Assert reset with three requests in flight → all outputs 0 in the same cycle. After release, no response appears for 10 cycles, and a new add returns normally at T+4.
